// File: rtl/control_unit_mc.sv
// control_unit_mc: multi-cycle control unit sequencing FETCH/EXEC/MEM_WAIT/FACT_WAIT/DONE.
// One instruction is latched per fetch handshake. Every output is a flop: the EXEC-phase
// strobes are decoded while the instruction is being latched, so they are valid for the
// whole EXEC cycle. They are then held through any memory or factorial wait and cleared
// on entry to DONE, where the PC update strobe is issued.
module control_unit_mc #(
    parameter int OPCODE_W     = 6,
    parameter int REG_ADDR_W   = 1,
    parameter int FACT_TIMEOUT = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     INSTR_VALID,
    output logic                     INSTR_ACK,
    input  logic [OPCODE_W-1:0]      OPCODE,
    input  logic [REG_ADDR_W-1:0]    REGISTER_ADDRESS,
    input  logic [1:0]               REGISTER_ADDRESS_STACK,
    input  logic [8:0]               IMMEDIATE,
    output logic [8:0]               IMM_OUT,
    input  logic [3:0]               FLAGS,
    input  logic                     MEM_READY,
    input  logic                     FACT_END,
    output logic                     ALU,
    output logic                     LOAD,
    output logic                     STORE,
    output logic                     COPY,
    output logic                     PUSH,
    output logic                     POP,
    output logic                     MOV,
    output logic                     FACT,
    output logic                     BRA,
    output logic                     SEL_FLAG,
    output logic                     SEL_ACC,
    output logic                     SEL_PC,
    output logic [2**REG_ADDR_W-1:0] SEL_REG,
    output logic                     PC_INC,
    output logic                     BUSY,
    output logic                     ILLEGAL,
    output logic                     FACT_TIMEOUT_ERR
);

    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int CNT_W    = $clog2(FACT_TIMEOUT + 1);

    // Opcodes are compared at full width, so any set upper bit makes an opcode illegal.
    localparam logic [OPCODE_W-1:0] OP_BRO       = OPCODE_W'(6'b000011);
    localparam logic [OPCODE_W-1:0] OP_BRA       = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ALU_FIRST = OPCODE_W'(6'b010000);
    localparam logic [OPCODE_W-1:0] OP_ALU_LAST  = OPCODE_W'(6'b010111);
    localparam logic [OPCODE_W-1:0] OP_CMP       = OPCODE_W'(6'b010100);
    localparam logic [OPCODE_W-1:0] OP_FACT      = OPCODE_W'(6'b011000);
    localparam logic [OPCODE_W-1:0] OP_MOV       = OPCODE_W'(6'b011001);
    localparam logic [OPCODE_W-1:0] OP_LOAD      = OPCODE_W'(6'b011010);
    localparam logic [OPCODE_W-1:0] OP_STORE     = OPCODE_W'(6'b011011);
    localparam logic [OPCODE_W-1:0] OP_COPY0     = OPCODE_W'(6'b011100);
    localparam logic [OPCODE_W-1:0] OP_COPY1     = OPCODE_W'(6'b011101);
    localparam logic [OPCODE_W-1:0] OP_PUSH      = OPCODE_W'(6'b011110);
    localparam logic [OPCODE_W-1:0] OP_POP       = OPCODE_W'(6'b011111);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM_WAIT,
        S_FACT_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [OPCODE_W-1:0]   ir_opcode_q, ir_opcode_d;
    logic [8:0]            imm_q, imm_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  alu_q, alu_d;
    logic                  load_q, load_d;
    logic                  store_q, store_d;
    logic                  copy_q, copy_d;
    logic                  push_q, push_d;
    logic                  pop_q, pop_d;
    logic                  mov_q, mov_d;
    logic                  fact_q, fact_d;
    logic                  bra_q, bra_d;
    logic                  sel_flag_q, sel_flag_d;
    logic                  sel_acc_q, sel_acc_d;
    logic                  sel_pc_q, sel_pc_d;
    logic [NUM_REGS-1:0]   sel_reg_q, sel_reg_d;
    logic                  pc_inc_q, pc_inc_d;
    logic                  busy_q, busy_d;
    logic                  illegal_q, illegal_d;
    logic                  fact_err_q, fact_err_d;

    logic [NUM_REGS-1:0]   reg_onehot;
    logic                  use_stack;
    logic                  go_done;

    assign reg_onehot = NUM_REGS'(1) << REGISTER_ADDRESS;

    // Next-state and next-output decode; go_done funnels every exit into DONE through one place.
    always_comb begin
        state_d     = state_q;
        ir_opcode_d = ir_opcode_q;
        imm_d       = imm_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;
        alu_d       = alu_q;
        load_d      = load_q;
        store_d     = store_q;
        copy_d      = copy_q;
        push_d      = push_q;
        pop_d       = pop_q;
        mov_d       = mov_q;
        fact_d      = fact_q;
        bra_d       = bra_q;
        sel_flag_d  = sel_flag_q;
        sel_acc_d   = sel_acc_q;
        sel_pc_d    = sel_pc_q;
        sel_reg_d   = sel_reg_q;
        pc_inc_d    = 1'b0;
        illegal_d   = 1'b0;
        fact_err_d  = 1'b0;
        use_stack   = 1'b0;
        go_done     = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (INSTR_VALID) begin
                    state_d     = S_EXEC;
                    ack_d       = 1'b1;
                    ir_opcode_d = OPCODE;
                    imm_d       = IMMEDIATE;
                    cnt_d       = '0;
                    if (OPCODE <= OP_BRO) begin
                        bra_d = FLAGS[2'd3 - OPCODE[1:0]];
                    end else if (OPCODE == OP_BRA) begin
                        bra_d = 1'b1;
                    end else if (OPCODE >= OP_ALU_FIRST && OPCODE <= OP_ALU_LAST) begin
                        alu_d      = 1'b1;
                        sel_flag_d = 1'b1;
                        if (OPCODE != OP_CMP) begin
                            sel_reg_d = reg_onehot;
                        end
                    end else if (OPCODE == OP_MOV) begin
                        mov_d     = 1'b1;
                        sel_reg_d = reg_onehot;
                    end else if (OPCODE == OP_COPY0) begin
                        copy_d    = 1'b1;
                        sel_reg_d = NUM_REGS'(1);
                    end else if (OPCODE == OP_COPY1) begin
                        copy_d    = 1'b1;
                        sel_reg_d = NUM_REGS'(2);
                    end else if (OPCODE == OP_LOAD) begin
                        load_d    = 1'b1;
                        sel_reg_d = reg_onehot;
                    end else if (OPCODE == OP_STORE) begin
                        store_d   = 1'b1;
                        sel_reg_d = reg_onehot;
                    end else if (OPCODE == OP_PUSH) begin
                        push_d    = 1'b1;
                        store_d   = 1'b1;
                        use_stack = 1'b1;
                    end else if (OPCODE == OP_POP) begin
                        pop_d     = 1'b1;
                        load_d    = 1'b1;
                        use_stack = 1'b1;
                    end else if (OPCODE == OP_FACT) begin
                        fact_d    = 1'b1;
                        sel_reg_d = reg_onehot;
                    end else begin
                        illegal_d = 1'b1;
                    end
                    if (use_stack) begin
                        case (REGISTER_ADDRESS_STACK)
                            2'd0:    sel_reg_d = NUM_REGS'(1);
                            2'd1:    sel_reg_d = NUM_REGS'(2);
                            2'd2:    sel_acc_d = 1'b1;
                            default: sel_pc_d  = 1'b1;
                        endcase
                    end
                end
            end
            S_EXEC: begin
                if (ir_opcode_q == OP_LOAD || ir_opcode_q == OP_STORE ||
                    ir_opcode_q == OP_PUSH || ir_opcode_q == OP_POP) begin
                    state_d = S_MEM_WAIT;
                end else if (ir_opcode_q == OP_FACT) begin
                    // The EXEC cycle already counts as the first cycle FACT is high.
                    state_d = S_FACT_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    go_done = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (MEM_READY) begin
                    go_done = 1'b1;
                end
            end
            S_FACT_WAIT: begin
                if (FACT_END) begin
                    go_done = 1'b1;
                end else if ((int'(cnt_q) + 1) >= FACT_TIMEOUT) begin
                    fact_err_d = 1'b1;
                    go_done    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (go_done) begin
            state_d    = S_DONE;
            pc_inc_d   = !bra_q && !(pop_q && sel_pc_q);
            alu_d      = 1'b0;
            load_d     = 1'b0;
            store_d    = 1'b0;
            copy_d     = 1'b0;
            push_d     = 1'b0;
            pop_d      = 1'b0;
            mov_d      = 1'b0;
            fact_d     = 1'b0;
            bra_d      = 1'b0;
            sel_flag_d = 1'b0;
            sel_acc_d  = 1'b0;
            sel_pc_d   = 1'b0;
            sel_reg_d  = '0;
        end

        busy_d = (state_d != S_FETCH);
    end

    // State, IR and all registered outputs; reset clears everything on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_FETCH;
            ir_opcode_q <= '0;
            imm_q       <= '0;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            alu_q       <= 1'b0;
            load_q      <= 1'b0;
            store_q     <= 1'b0;
            copy_q      <= 1'b0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            mov_q       <= 1'b0;
            fact_q      <= 1'b0;
            bra_q       <= 1'b0;
            sel_flag_q  <= 1'b0;
            sel_acc_q   <= 1'b0;
            sel_pc_q    <= 1'b0;
            sel_reg_q   <= '0;
            pc_inc_q    <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
            fact_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_opcode_q <= ir_opcode_d;
            imm_q       <= imm_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            alu_q       <= alu_d;
            load_q      <= load_d;
            store_q     <= store_d;
            copy_q      <= copy_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            mov_q       <= mov_d;
            fact_q      <= fact_d;
            bra_q       <= bra_d;
            sel_flag_q  <= sel_flag_d;
            sel_acc_q   <= sel_acc_d;
            sel_pc_q    <= sel_pc_d;
            sel_reg_q   <= sel_reg_d;
            pc_inc_q    <= pc_inc_d;
            busy_q      <= busy_d;
            illegal_q   <= illegal_d;
            fact_err_q  <= fact_err_d;
        end
    end

    assign INSTR_ACK        = ack_q;
    assign IMM_OUT          = imm_q;
    assign ALU              = alu_q;
    assign LOAD             = load_q;
    assign STORE            = store_q;
    assign COPY             = copy_q;
    assign PUSH             = push_q;
    assign POP              = pop_q;
    assign MOV              = mov_q;
    assign FACT             = fact_q;
    assign BRA              = bra_q;
    assign SEL_FLAG         = sel_flag_q;
    assign SEL_ACC          = sel_acc_q;
    assign SEL_PC           = sel_pc_q;
    assign SEL_REG          = sel_reg_q;
    assign PC_INC           = pc_inc_q;
    assign BUSY             = busy_q;
    assign ILLEGAL          = illegal_q;
    assign FACT_TIMEOUT_ERR = fact_err_q;

endmodule
